// File: rtl/mod_n_down_counter_pkg.sv
// Shared definitions for the modulo-N down counter: reset polarity, operation
// encoding and a ceil(log2) helper for sizing WIDTH from MOD.
package mod_n_down_counter_pkg;

  localparam logic CNT_RST_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_LOAD,
    OP_DEC,
    OP_WRAP
  } cnt_op_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/mod_n_down_counter_dff_sync_rst.sv
// Single D flip-flop with synchronous reset to a per-instance value.
module dff_sync_rst
  import mod_n_down_counter_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  // NOTE: reset is sampled only at the clock edge (synchronous), and state
  // always updates with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst == CNT_RST_LEVEL) q <= RST_VAL;
    else                      q <= d;
  end

endmodule

// File: rtl/mod_n_down_counter.sv
// Loadable modulo-MOD down counter built from dff_sync_rst bit cells.
// Define DOWNCNT_HOLD_AT_ZERO_EN for one-shot mode (count sticks at zero).
module mod_n_down_counter
  import mod_n_down_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

`ifdef DOWNCNT_HOLD_AT_ZERO_EN
  localparam logic [WIDTH-1:0] WRAP_VAL = '0;
`else
  localparam logic [WIDTH-1:0] WRAP_VAL = MAX_VAL;
`endif

  cnt_op_e          op;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] load_clamped;
  logic             done_q, done_d;
  logic             q_is_zero;

  assign q_is_zero = (q_q == '0);

  assign op = load ? OP_LOAD
            : en   ? (q_is_zero ? OP_WRAP : OP_DEC)
            :        OP_HOLD;

  // Widened compare so MOD == 2**WIDTH stays representable.
  assign load_clamped = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;

  assign q_d = (op == OP_LOAD) ? load_clamped
             : (op == OP_DEC)  ? q_q - ONE
             : (op == OP_WRAP) ? WRAP_VAL
             :                   q_q;

  assign done_d = (op == OP_DEC) && (q_q == ONE);

  for (genvar i = 0; i < WIDTH; i++) begin : g_q_bit
    dff_sync_rst #(.RST_VAL(MAX_VAL[i])) u_dff (
      .clk (clk),
      .rst (rst),
      .d   (q_d[i]),
      .q   (q_q[i])
    );
  end

  dff_sync_rst #(.RST_VAL(1'b0)) u_done_dff (
    .clk (clk),
    .rst (rst),
    .d   (done_d),
    .q   (done_q)
  );

  assign q    = q_q;
  assign done = done_q;
  assign tc   = en & q_is_zero;

endmodule
